awstm_evt_queue: RTL and testbench

//  Downstream consumer of the aws timer event word (lock flag in bit 31, 10 s time in bits 30:0).
//  - Detects each new event word and stores it in a small FIFO.
//  - Presents the FIFO head to the PS7 through the axi-gpio.
//  - Raises a level interrupt, so no event is lost if software services the IRQ late.
//  - Flags pps lock/unlock transitions and FIFO overruns.

---
 rtl/awstm_pkg.sv | 20 ++
 rtl/awstm_evt_queue_if.sv | 29 ++
 rtl/awstm_sync_fifo.sv | 56 +++++
 rtl/awstm_evt_queue.sv | 105 ++++++++++
 tb/tb_awstm_evt_queue.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/awstm_pkg.sv
// Shared definitions for the aws timer event word: field layout, widths and
// the wrap value of the 10 s cycle counter.
package awstm_pkg;

    localparam int EVT_W        = 32;
    localparam int EVT_LOCK_BIT = 31;
    localparam int P_AWSTM_MAX  = 999_999_999;

    typedef struct packed {
        logic        lock;
        logic [30:0] time_cnt;
    } awstm_evt_t;

    function automatic logic evt_lock(input logic [EVT_W-1:0] word);
        awstm_evt_t e;
        e = awstm_evt_t'(word);
        return e.lock;
    endfunction

endpackage

// File: rtl/awstm_evt_queue_if.sv
// GPIO-facing side of the event queue: pop/clear levels from software,
// FIFO head, occupancy and status flags back to it.
interface awstm_evt_queue_if #(
    parameter int AW    = 4,
    parameter int OVF_W = 16
);
    import awstm_pkg::*;

    logic             rd_ack;
    logic             clr;
    logic [EVT_W-1:0] rd_data;
    logic             rd_valid;
    logic [AW:0]      level;
    logic [OVF_W-1:0] ovf_cnt;
    logic             lock_chg;
    logic             ovf;
    logic             irq;

    modport master (
        output rd_ack, clr,
        input  rd_data, rd_valid, level, ovf_cnt, lock_chg, ovf, irq
    );

    modport slave (
        input  rd_ack, clr,
        output rd_data, rd_valid, level, ovf_cnt, lock_chg, ovf, irq
    );

endinterface

// File: rtl/awstm_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with wrap-bit pointers; rejects
// pushes when full (unless a pop frees a slot) and pops when empty.
module awstm_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic [AW:0]      level,
    output logic [AW:0]      level_nxt,
    output logic             drop
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wp;
    logic [AW:0]      rp;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (wp == rp);
    assign full    = ((wp ^ rp) == {1'b1, {AW{1'b0}}});
    assign pop_ok  = pop & ~empty;
    // A pop on a full FIFO frees the slot the push needs, so both proceed.
    assign push_ok = push & (~full | pop_ok);
    assign drop    = push & ~push_ok;

    assign level     = wp - rp;
    assign level_nxt = level + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    assign rd_data   = empty ? '0 : mem[rp[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push_ok) wp <= wp + 1'b1;
            if (pop_ok)  rp <= rp + 1'b1;
        end
    end

    // NOTE: the storage array has no reset; empty gating on rd_data hides
    // stale contents, and a resettable array would not map onto RAM.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wp[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/awstm_evt_queue.sv
// Captures each new aws timer event word into a FIFO read by software over
// axi-gpio, with sticky lock-change/overrun flags and a level interrupt.
module awstm_evt_queue
    import awstm_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int OVF_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [EVT_W-1:0] evt,
    awstm_evt_queue_if.slave gpio
);

    localparam logic [OVF_W-1:0] CNT_ONE = OVF_W'(1);

    logic [EVT_W-1:0] r_evt_prev;
    logic             r_ack_prev;
    logic             r_clr_prev;
    logic             new_evt;
    logic             pop_req;
    logic             clr_edge;
    logic             lock_set;
    logic             overrun;
    logic             fifo_empty;
    logic [AW:0]      level_nxt;

    logic             lock_chg_q, lock_chg_nxt;
    logic             ovf_q, ovf_nxt;
    logic [OVF_W-1:0] ovf_cnt_q, ovf_cnt_nxt;
    logic             irq_q, irq_nxt;

    // Prev register resets to 0, so a nonzero word right after reset is an event.
    assign new_evt  = (evt != r_evt_prev);
    assign pop_req  = gpio.rd_ack & ~r_ack_prev;
    assign clr_edge = gpio.clr & ~r_clr_prev;
    assign lock_set = new_evt & (evt_lock(evt) != evt_lock(r_evt_prev));

    awstm_sync_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (new_evt),
        .pop       (pop_req),
        .wr_data   (evt),
        .rd_data   (gpio.rd_data),
        .empty     (fifo_empty),
        .level     (gpio.level),
        .level_nxt (level_nxt),
        .drop      (overrun)
    );

    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        lock_chg_nxt = lock_chg_q;
        ovf_nxt      = ovf_q;
        ovf_cnt_nxt  = ovf_cnt_q;

        if (clr_edge) begin
            lock_chg_nxt = 1'b0;
            ovf_nxt      = 1'b0;
            ovf_cnt_nxt  = '0;
        end
        // Sets are applied after the clear so a coincident set wins.
        if (lock_set) lock_chg_nxt = 1'b1;
        if (overrun) begin
            ovf_nxt     = 1'b1;
            ovf_cnt_nxt = clr_edge ? CNT_ONE
                        : (&ovf_cnt_q) ? ovf_cnt_q : ovf_cnt_q + CNT_ONE;
        end

        irq_nxt = (level_nxt != '0) | lock_chg_nxt | ovf_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_evt_prev <= '0;
            r_ack_prev <= 1'b0;
            r_clr_prev <= 1'b0;
            lock_chg_q <= 1'b0;
            ovf_q      <= 1'b0;
            ovf_cnt_q  <= '0;
            irq_q      <= 1'b0;
        end else begin
            r_evt_prev <= evt;
            r_ack_prev <= gpio.rd_ack;
            r_clr_prev <= gpio.clr;
            lock_chg_q <= lock_chg_nxt;
            ovf_q      <= ovf_nxt;
            ovf_cnt_q  <= ovf_cnt_nxt;
            irq_q      <= irq_nxt;
        end
    end

    assign gpio.rd_valid = ~fifo_empty;
    assign gpio.lock_chg = lock_chg_q;
    assign gpio.ovf      = ovf_q;
    assign gpio.ovf_cnt  = ovf_cnt_q;
    assign gpio.irq      = irq_q;

endmodule

// File: tb/tb_awstm_evt_queue.sv
// Self-checking bench for awstm_evt_queue: directed tables and sequences plus
// random traffic compared against a queue-based reference model.
module tb_awstm_evt_queue;
    import awstm_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int OVF_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [EVT_W-1:0] evt = '0;

    awstm_evt_queue_if #(.AW(AW), .OVF_W(OVF_W)) bus ();

    awstm_evt_queue #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .OVF_W (OVF_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .evt   (evt),
        .gpio  (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the FIFO is a queue, flags follow the event rules directly.
    logic [31:0]      mq[$];
    logic [31:0]      m_prev;
    logic             m_ack_prev, m_clr_prev, m_lock, m_ovf;
    logic [OVF_W-1:0] m_cnt;

    task automatic model_reset();
        mq.delete();
        m_prev = '0; m_ack_prev = 1'b0; m_clr_prev = 1'b0;
        m_lock = 1'b0; m_ovf = 1'b0; m_cnt = '0;
    endtask

    task automatic model_step();
        logic is_new, pop, cedge, ovr;
        is_new = (evt != m_prev);
        pop    = bus.rd_ack && !m_ack_prev;
        cedge  = bus.clr && !m_clr_prev;
        ovr    = 1'b0;
        if (pop && mq.size() > 0) void'(mq.pop_front());
        if (is_new) begin
            if (mq.size() < DEPTH) mq.push_back(evt);
            else ovr = 1'b1;
        end
        if (cedge) begin
            m_lock = 1'b0; m_ovf = 1'b0; m_cnt = '0;
        end
        if (is_new && evt[31] != m_prev[31]) m_lock = 1'b1;
        if (ovr) begin
            m_ovf = 1'b1;
            if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
        end
        m_prev = evt; m_ack_prev = bus.rd_ack; m_clr_prev = bus.clr;
    endtask

    task automatic check_all(input string tag);
        logic [31:0] exp_data;
        exp_data = (mq.size() > 0) ? mq[0] : 32'h0;
        check({tag, "_level"},    32'(bus.level),    mq.size());
        check({tag, "_rd_valid"}, 32'(bus.rd_valid), (mq.size() > 0) ? 1 : 0);
        check({tag, "_rd_data"},  bus.rd_data,       exp_data);
        check({tag, "_lock_chg"}, 32'(bus.lock_chg), 32'(m_lock));
        check({tag, "_ovf"},      32'(bus.ovf),      32'(m_ovf));
        check({tag, "_ovf_cnt"},  32'(bus.ovf_cnt),  32'(m_cnt));
        check({tag, "_irq"},      32'(bus.irq),      32'((mq.size() > 0) || m_lock || m_ovf));
    endtask

    // One clock: advance the model with the applied inputs, then compare #1 after the edge.
    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        evt = '0; bus.rd_ack = 1'b0; bus.clr = 1'b0;
        repeat (3) @(posedge clk);
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [31:0] evt;
        logic        ack;
        logic        clr;
        int          exp_level;
        logic [31:0] exp_data;
        logic        exp_lock;
        logic        exp_irq;
    } vec_t;

    vec_t vt [8];

    initial begin
        bus.rd_ack = 1'b0;
        bus.clr    = 1'b0;

        // Basic push/pop table: two events, clear the power-up lock flag, two pops, idle pop.
        vt[0] = '{32'h8000_0064, 1'b0, 1'b0, 1, 32'h8000_0064, 1'b1, 1'b1};
        vt[1] = '{32'h8098_96E4, 1'b0, 1'b0, 2, 32'h8000_0064, 1'b1, 1'b1};
        vt[2] = '{32'h8098_96E4, 1'b1, 1'b0, 1, 32'h8098_96E4, 1'b1, 1'b1};
        vt[3] = '{32'h8098_96E4, 1'b0, 1'b1, 1, 32'h8098_96E4, 1'b0, 1'b1};
        vt[4] = '{32'h8098_96E4, 1'b1, 1'b1, 0, 32'h0000_0000, 1'b0, 1'b0};
        vt[5] = '{32'h8098_96E4, 1'b0, 1'b0, 0, 32'h0000_0000, 1'b0, 1'b0};
        vt[6] = '{32'h8098_96E4, 1'b1, 1'b0, 0, 32'h0000_0000, 1'b0, 1'b0};
        vt[7] = '{32'h8098_96E4, 1'b0, 1'b0, 0, 32'h0000_0000, 1'b0, 1'b0};

        // 1. Reset state with evt held at 0.
        do_reset();
        check("rst_level", 32'(bus.level), 0);
        check("rst_irq",   32'(bus.irq),   0);
        for (int i = 0; i < 100; i++) begin
            cycle("idle");
            check("idle_rd_valid", 32'(bus.rd_valid), 0);
            check("idle_rd_data",  bus.rd_data,       0);
        end

        // 2. Table-driven push/pop.
        for (int i = 0; i < 8; i++) begin
            evt = vt[i].evt; bus.rd_ack = vt[i].ack; bus.clr = vt[i].clr;
            cycle("tbl");
            check($sformatf("tbl%0d_level", i), 32'(bus.level),    vt[i].exp_level);
            check($sformatf("tbl%0d_data", i),  bus.rd_data,       vt[i].exp_data);
            check($sformatf("tbl%0d_lock", i),  32'(bus.lock_chg), 32'(vt[i].exp_lock));
            check($sformatf("tbl%0d_irq", i),   32'(bus.irq),      32'(vt[i].exp_irq));
        end

        // 3. Overrun: 20 distinct words into a 16-deep FIFO, then clear.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            evt = 32'h8000_0100 + 32'(i * 16);
            cycle("ovr");
        end
        check("ovr_level", 32'(bus.level),   16);
        check("ovr_ovf",   32'(bus.ovf),     1);
        check("ovr_cnt",   32'(bus.ovf_cnt), 4);
        check("ovr_head",  bus.rd_data,      32'h8000_0100);
        bus.clr = 1'b1;
        cycle("clr");
        check("clr_ovf",   32'(bus.ovf),     0);
        check("clr_cnt",   32'(bus.ovf_cnt), 0);
        check("clr_level", 32'(bus.level),   16);
        check("clr_irq",   32'(bus.irq),     1);
        bus.clr = 1'b0;
        cycle("clr");

        // 4. Full FIFO: push and pop in the same cycle.
        evt = 32'h8000_0900; bus.rd_ack = 1'b1;
        cycle("fpp");
        check("fpp_level", 32'(bus.level),   16);
        check("fpp_cnt",   32'(bus.ovf_cnt), 0);
        check("fpp_head",  bus.rd_data,      32'h8000_0110);
        for (int i = 0; i < 15; i++) begin
            bus.rd_ack = 1'b0; cycle("drain");
            bus.rd_ack = 1'b1; cycle("drain");
        end
        check("tail_level", 32'(bus.level), 1);
        check("tail_word",  bus.rd_data,    32'h8000_0900);
        bus.rd_ack = 1'b0; cycle("drain");
        bus.rd_ack = 1'b1; cycle("drain");
        check("drain_level", 32'(bus.level), 0);

        // 5. Lock change, and set winning over a coincident clear.
        do_reset();
        evt = 32'h8000_1000; cycle("lk");
        bus.clr = 1'b1;      cycle("lk");
        check("lk_cleared", 32'(bus.lock_chg), 0);
        bus.clr = 1'b0;
        evt = 32'h0000_2000; cycle("lk");
        check("lk_set", 32'(bus.lock_chg), 1);
        check("lk_irq", 32'(bus.irq),      1);
        bus.clr = 1'b1; evt = 32'h8000_3000; cycle("lk");
        check("lk_set_wins", 32'(bus.lock_chg), 1);
        bus.clr = 1'b0; cycle("lk");
        bus.clr = 1'b1; cycle("lk");
        check("lk_clr", 32'(bus.lock_chg), 0);
        bus.clr = 1'b0; cycle("lk");

        // 6. rd_ack held high pops once; async reset mid-stream.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            evt = 32'h0000_0010 + 32'(i); cycle("hold");
        end
        bus.rd_ack = 1'b1;
        for (int i = 0; i < 50; i++) cycle("hold");
        check("hold_level", 32'(bus.level), 2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_level",    32'(bus.level),    0);
        check("arst_rd_valid", 32'(bus.rd_valid), 0);
        check("arst_rd_data",  bus.rd_data,       0);
        check("arst_irq",      32'(bus.irq),      0);
        check("arst_lock",     32'(bus.lock_chg), 0);
        check("arst_ovf",      32'(bus.ovf),      0);
        check("arst_cnt",      32'(bus.ovf_cnt),  0);
        bus.rd_ack = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycle("rel");
        check("rel_level", 32'(bus.level), 1);
        check("rel_head",  bus.rd_data,    32'h0000_0012);

        // Random traffic against the model, alternating light and heavy pop rates.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int ack_pct;
            ack_pct = ((i / 300) % 2 == 0) ? 8 : 60;
            if ($urandom_range(99) < 40) evt = $urandom;
            bus.rd_ack = ($urandom_range(99) < ack_pct);
            bus.clr    = ($urandom_range(99) < 4);
            cycle("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
